// File: rtl/ps2_pkg.sv
// Shared PS/2 byte constants, parser state encoding, event layout and the
// default arrow-key table used by the key event queue.
package ps2_pkg;

  localparam logic [7:0] BYTE_E0  = 8'hE0;
  localparam logic [7:0] BYTE_F0  = 8'hF0;
  localparam logic [7:0] BYTE_BAT = 8'hAA;
  localparam logic [7:0] BYTE_ACK = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
  } ps2_event_t;

  // Entry 0 in the low bits: up, down, left, right (all E0-extended).
  localparam logic [35:0] DEFAULT_KEY_CODES = {9'h174, 9'h16B, 9'h172, 9'h175};

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO; head is visible on rd_data (zero while empty).
module event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign count   = count_q;
  assign do_pop  = rd_en && !empty;
  // A pop frees the slot the push lands in, so push-while-full is fine then.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser: completed make/break codes are queued as events and
// a small table of tracked keys reports which are currently held down.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int                    DEPTH         = 4,
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = DEFAULT_KEY_CODES,
  parameter bit                    IGNORE_REPEAT = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        key_en,
  input  logic [7:0]                  key_data,
  input  logic                        ev_ready,
  output logic                        ev_valid,
  output logic [7:0]                  ev_keycode,
  output logic                        ev_make,
  output logic                        ev_ext,
  output logic [7:0]                  keycode,
  output logic                        key_make,
  output logic                        key_ext,
  output logic [NUM_KEYS-1:0]         held,
  output logic                        overflow,
  output logic [$clog2(DEPTH+1)-1:0]  ev_count
);
  ps2_state_e         state_q, state_d;
  logic               done, done_make, done_ext;
  logic [7:0]         keycode_q;
  logic               key_make_q, key_ext_q, overflow_q;
  logic [NUM_KEYS-1:0] held_q, held_d, key_match;
  logic               repeat_hit, push;
  logic               fifo_full, fifo_empty;
  ps2_event_t         push_ev, head_ev;

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    done_make = 1'b0;
    done_ext  = 1'b0;
    if (key_en) begin
      // E0 always (re)starts an extended sequence, including a repeated E0.
      if (key_data == BYTE_E0) begin
        state_d = ST_GOT_E0;
      end else if (key_data == BYTE_F0) begin
        if (state_q == ST_IDLE)        state_d = ST_GOT_F0;
        else if (state_q == ST_GOT_E0) state_d = ST_GOT_E0F0;
      end else if (state_q == ST_IDLE &&
                   (key_data == BYTE_BAT || key_data == BYTE_ACK)) begin
        state_d = ST_IDLE;
      end else begin
        done      = 1'b1;
        done_make = (state_q == ST_IDLE) || (state_q == ST_GOT_E0);
        done_ext  = (state_q == ST_GOT_E0) || (state_q == ST_GOT_E0F0);
        state_d   = ST_IDLE;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    assign key_match[gi] = done && ({done_ext, key_data} == KEY_CODES[gi*9 +: 9]);
    assign held_d[gi]    = key_match[gi] ? done_make : held_q[gi];
  end

  assign repeat_hit = IGNORE_REPEAT && done_make && |(key_match & held_q);
  assign push       = done && !repeat_hit;
  assign push_ev    = '{ext: done_ext, make: done_make, code: key_data};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      keycode_q  <= '0;
      key_make_q <= 1'b0;
      key_ext_q  <= 1'b0;
      held_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      if (done) begin
        keycode_q  <= key_data;
        key_make_q <= done_make;
        key_ext_q  <= done_ext;
      end
      // When full the FIFO is non-empty, so ev_ready alone means a pop.
      if (push && fifo_full && !ev_ready) overflow_q <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH(10),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_ev),
    .rd_en   (ev_ready),
    .rd_data (head_ev),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (ev_count)
  );

  assign ev_valid   = !fifo_empty;
  assign ev_keycode = head_ev.code;
  assign ev_make    = head_ev.make;
  assign ev_ext     = head_ev.ext;
  assign keycode    = keycode_q;
  assign key_make   = key_make_q;
  assign key_ext    = key_ext_q;
  assign held       = held_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Randomized and directed bench for ps2_key_event_queue against a queue-based
// behavioural model of the PS/2 parsing, held-key and FIFO rules.
module tb_ps2_key_event_queue;
  localparam int DEPTH    = 4;
  localparam int NUM_KEYS = 4;
  localparam bit IGN_REP  = 1'b1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_en = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_make, ev_ext, key_make, key_ext, overflow;
  logic [7:0] ev_keycode, keycode;
  logic [NUM_KEYS-1:0] held;
  logic [2:0] ev_count;

  ps2_key_event_queue #(
    .DEPTH(DEPTH), .NUM_KEYS(NUM_KEYS), .IGNORE_REPEAT(IGN_REP)
  ) dut (
    .clk(clk), .resetn(resetn), .key_en(key_en), .key_data(key_data),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_keycode(ev_keycode),
    .ev_make(ev_make), .ev_ext(ev_ext), .keycode(keycode),
    .key_make(key_make), .key_ext(key_ext), .held(held),
    .overflow(overflow), .ev_count(ev_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Model state: tracked keys {ext,code}: up, down, left, right.
  logic [8:0] key_tab [NUM_KEYS] = '{9'h175, 9'h172, 9'h16B, 9'h174};
  logic [9:0] mq [$];
  bit         m_pend_ext, m_pend_brk;
  logic [7:0] m_code;
  bit         m_make, m_ext, m_ovf;
  bit [NUM_KEYS-1:0] m_held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pop, mk, ex, rep;
    logic [9:0] dummy;
    if (!resetn) begin
      mq.delete();
      m_pend_ext = 0; m_pend_brk = 0;
      m_code = 8'h00; m_make = 0; m_ext = 0; m_ovf = 0; m_held = '0;
      return;
    end
    pop = (mq.size() > 0) && ev_ready;
    if (pop) dummy = mq.pop_front();
    if (key_en) begin
      if (key_data == 8'hE0) begin
        m_pend_ext = 1; m_pend_brk = 0;
      end else if (key_data == 8'hF0) begin
        m_pend_brk = 1;
      end else if (!m_pend_ext && !m_pend_brk && (key_data == 8'hAA || key_data == 8'hFA)) begin
        // discarded
      end else begin
        mk = !m_pend_brk;
        ex = m_pend_ext;
        m_pend_ext = 0; m_pend_brk = 0;
        m_code = key_data; m_make = mk; m_ext = ex;
        rep = 0;
        for (int i = 0; i < NUM_KEYS; i++)
          if ({ex, key_data} == key_tab[i] && mk && m_held[i]) rep = 1;
        for (int i = 0; i < NUM_KEYS; i++)
          if ({ex, key_data} == key_tab[i]) m_held[i] = mk;
        if (!(rep && IGN_REP)) begin
          if (mq.size() < DEPTH) mq.push_back({ex, mk, key_data});
          else m_ovf = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    key_en = 1'b1; key_data = b;
    cycle();
    key_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  task automatic pop_n(input int n);
    ev_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    ev_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
      chk("ev_head", 32'({ev_ext, ev_make, ev_keycode}), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      chk("ev_count", 32'(ev_count), 32'(mq.size()));
      chk("keycode", 32'(keycode), 32'(m_code));
      chk("key_make", 32'(key_make), 32'(m_make));
      chk("key_ext", 32'(key_ext), 32'(m_ext));
      chk("held", 32'(held), 32'(m_held));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  initial begin
    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h75, 8'h72,
                              8'h6B, 8'h74, 8'h1C, 8'h15, 8'hE0, 8'hF0};
    logic [7:0] fill [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    resetn = 1'b0;
    cycle(); cycle(); cycle();
    check_en = 1'b1;
    chk("rst_count", 32'(ev_count), 32'h0);
    chk("rst_keycode", 32'(keycode), 32'h0);
    resetn = 1'b1;

    // Plain make
    send(8'h1C);
    chk("mk_keycode", 32'(keycode), 32'h1C);
    chk("mk_head", 32'({ev_ext, ev_make, ev_keycode}), 32'h11C);
    pop_n(1);

    // Extended make then break of tracked key 0
    send(8'hE0); send(8'h75);
    chk("up_held", 32'(held), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_released", 32'(held), 32'h0);
    chk("up_head_make", 32'({ev_ext, ev_make, ev_keycode}), 32'h375);
    pop_n(1);
    chk("up_head_break", 32'({ev_ext, ev_make, ev_keycode}), 32'h275);
    pop_n(1);

    // Typematic repeat suppression
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h6B); end
    chk("rep_count", 32'(ev_count), 32'h1);
    chk("rep_held", 32'(held), 32'h4);
    chk("rep_keycode", 32'(keycode), 32'h6B);
    pop_n(1);

    // Reset abandons a pending prefix; BAT/ACK discarded
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("rst_prefix_head", 32'({ev_ext, ev_make, ev_keycode}), 32'h11C);
    send(8'hAA); send(8'hFA);
    chk("bat_ack_count", 32'(ev_count), 32'h1);
    pop_n(1);

    // Overflow
    do_reset();
    for (int i = 0; i < 5; i++) send(fill[i]);
    chk("ovf_count", 32'(ev_count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_head", 32'({ev_ext, ev_make, ev_keycode}), 32'h115);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 4; i++) send(fill[i]);
    ev_ready = 1'b1;
    send(fill[4]);
    ev_ready = 1'b0;
    chk("pp_count", 32'(ev_count), 32'(DEPTH));
    chk("pp_ovf", 32'(overflow), 32'h0);
    chk("pp_head", 32'({ev_ext, ev_make, ev_keycode}), 32'h11D);
    pop_n(3);
    chk("pp_tail", 32'({ev_ext, ev_make, ev_keycode}), 32'h12C);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      key_en   = ($urandom_range(0, 99) < 55);
      key_data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      ev_ready = ($urandom_range(0, 99) < 30);
      resetn   = ($urandom_range(0, 299) != 0);
      cycle();
    end
    key_en = 1'b0; ev_ready = 1'b0; resetn = 1'b1;
    cycle();

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_queue.md
PS2_KEY_EVENT_QUEUE -- requirements
Module: ps2_key_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter NUM_KEYS, default 4, number of tracked keys.
REQ-003 SHALL have parameter KEY_CODES, NUM_KEYS*9 bits, entry i = {ext, code[7:0]}; default = up {1,75h}, down {1,72h}, left {1,6Bh}, right {1,74h}; entry 0 is the low bits.
REQ-004 SHALL have parameter IGNORE_REPEAT, default 1, which suppresses typematic repeats of held tracked keys.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 key_en  in  1  one-cycle strobe: key_data is a valid received PS/2 byte.
REQ-008 key_data  in  8  received PS/2 byte.
REQ-009 ev_ready  in  1  consumer accepts the head event.
REQ-010 ev_valid  out  1  FIFO non-empty.
REQ-011 ev_keycode  out  8  head event code.
REQ-012 ev_make  out  1  head event: 1 = make, 0 = break.
REQ-013 ev_ext  out  1  head event extended (E0-prefixed).
REQ-014 keycode  out  8  last completed code.
REQ-015 key_make  out  1  last completed code was a make.
REQ-016 key_ext  out  1  last completed code was extended.
REQ-017 held  out  NUM_KEYS  bit i = tracked key i currently pressed.
REQ-018 overflow  out  1  sticky flag: an event was dropped.
REQ-019 ev_count  out  clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-020 SHALL parse bytes with FSM IDLE, GOT_E0, GOT_F0, GOT_E0F0, advancing only on cycles with key_en=1.
REQ-021 SHALL transition IDLE on E0h to GOT_E0, IDLE on F0h to GOT_F0, and GOT_E0 on F0h to GOT_E0F0.
REQ-022 SHALL treat E0h in GOT_F0 or GOT_E0F0 as a protocol restart to GOT_E0, and SHALL leave the state unchanged on F0h in GOT_F0 or GOT_E0F0.
REQ-023 SHALL, on any other byte, complete a code: IDLE gives make/ext=0, GOT_E0 gives make/ext=1, GOT_F0 gives break/ext=0, GOT_E0F0 gives break/ext=1; the FSM then returns to IDLE.
REQ-024 SHALL discard AAh (BAT) and FAh (ACK) received in IDLE, with no event generated and no output change.
REQ-025 SHALL update keycode/key_make/key_ext exactly 1 cycle after the key_en of the completing byte, independent of FIFO state.
REQ-026 SHALL, on a completed code matching KEY_CODES[i] ({ext,code} both equal), set held[i] on make and clear it on break, with the same 1-cycle latency.
REQ-027 SHALL NOT push a make of tracked key i into the FIFO when IGNORE_REPEAT=1 and held[i]=1; keycode, key_make and key_ext still update for that make.
REQ-028 SHALL push every other completed code into the FIFO as {ext, make, code} 1 cycle after the final key_en.
REQ-029 SHALL present the FIFO head show-ahead on ev_keycode/ev_make/ev_ext while ev_valid=1, and SHALL drive all three as 0 when ev_valid=0.
REQ-030 SHALL pop the FIFO on a cycle with ev_valid && ev_ready; ev_ready while empty SHALL have no effect.
REQ-031 SHALL, on a push while full without a same-cycle pop, drop the new event and set overflow; overflow SHALL clear only on reset.
REQ-032 SHALL, on a simultaneous push and pop, accept both, including when full, leaving ev_count unchanged.
REQ-033 SHALL wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-034 SHALL, while resetn=0 at a clock edge, set FSM=IDLE, FIFO empty, ev_count=0, held=0, overflow=0, keycode=0, key_make=0, key_ext=0, and SHALL ignore key_en.
REQ-035 SHALL abandon a partially received prefix sequence when reset is asserted mid-sequence; the next byte after reset SHALL be parsed from IDLE.

Structure
REQ-036 SHALL take byte constants E0h, F0h, AAh, FAh, the FSM state encoding and the default arrow KEY_CODES from shared package ps2_pkg.
REQ-037 SHALL implement the FIFO as sub-module event_fifo (parameters WIDTH=10, DEPTH), synchronous, show-ahead, with full/empty/count outputs.

Verification
REQ-038 Bytes 1Ch -> 1 cycle later keycode=1Ch, key_make=1, key_ext=0; ev_valid=1, head {0,1,1Ch}.
REQ-039 Bytes E0h,F0h,75h (after a prior E0h,75h) -> held[0] goes 1 then 0; events {1,1,75h} then {1,0,75h}.
REQ-040 E0h,6Bh sent three times with IGNORE_REPEAT=1 -> exactly one event, held[2]=1, keycode=6Bh.
REQ-041 DEPTH+1 distinct makes with ev_ready=0 -> ev_count=DEPTH, overflow=1, head is the first code, last code dropped.
REQ-042 FIFO full, push and pop in the same cycle -> ev_count stays DEPTH, overflow stays 0, new event at tail.
REQ-043 E0h, then resetn=0 for one cycle, then 1Ch -> make event ext=0, code 1Ch; AAh or FAh alone -> no event.
